// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction, misalign detect and writeback select
// Inputs : clk, reset (sync, active-high), stall, flush, MEM-stage instruction fields
//          (valid_M, pc_M, alu_M, dm_dout_M, rd_M, RegWrite_M, MemRead_M, DMType_M, WDSel_M)
// Outputs: valid_W, pcW, rd_W, RegWrite_W, wd_W, misalign_W, all registered
// Option : MEM_WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output
module mem_wb_stage #(
    parameter int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_M,
    input  logic [XLEN-1:0] pc_M,
    input  logic [XLEN-1:0] alu_M,
    input  logic [XLEN-1:0] dm_dout_M,
    input  logic [4:0]      rd_M,
    input  logic            RegWrite_M,
    input  logic            MemRead_M,
    input  logic [2:0]      DMType_M,
    input  logic [1:0]      WDSel_M,
    output logic            valid_W,
    output logic [XLEN-1:0] pcW,
    output logic [4:0]      rd_W,
    output logic            RegWrite_W,
    output logic [XLEN-1:0] wd_W,
`ifdef MEM_WB_RETIRE_CNT_EN
    output logic [63:0]     retire_cnt,
`endif
    output logic            misalign_W
);
    logic [1:0]      off;
    logic            is_half, is_byte, is_word, sext;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_v;
    logic            mis;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic            mis_q, mis_d;

    always_comb begin
        off     = alu_M[1:0];
        is_half = (DMType_M == 3'b001) || (DMType_M == 3'b010);
        is_byte = (DMType_M == 3'b011) || (DMType_M == 3'b100);
        is_word = !is_half && !is_byte;
        sext    = (DMType_M == 3'b001) || (DMType_M == 3'b011);
        byte_v  = off == 2'd0 ? dm_dout_M[7:0]   :
                  off == 2'd1 ? dm_dout_M[15:8]  :
                  off == 2'd2 ? dm_dout_M[23:16] : dm_dout_M[31:24];
        half_v  = off[1] ? dm_dout_M[31:16] : dm_dout_M[15:0];
        load_v  = is_byte ? {{(XLEN-8){sext & byte_v[7]}}, byte_v} :
                  is_half ? {{(XLEN-16){sext & half_v[15]}}, half_v} : dm_dout_M;
        mis     = MemRead_M && valid_M && ((is_half && off[0]) || (is_word && off != 2'd0));
        valid_d = valid_M;
        pc_d    = pc_M;
        rd_d    = rd_M;
        mis_d   = mis;
        we_d    = RegWrite_M && valid_M && (rd_M != 5'd0) && !mis;
        wd_d    = mis                ? '0 :
                  WDSel_M == 2'b01   ? load_v :
                  WDSel_M == 2'b10   ? pc_M + XLEN'(4) : alu_M;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            mis_q   <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            mis_q   <= mis_d;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;
    logic        held_q, held_d;

    // An instruction sitting in WB is counted on the first edge it is seen;
    // edges following a stall hold see the same instruction again and skip it.
    always_comb begin
        cnt_d  = (valid_q && !held_q) ? cnt_q + 64'd1 : cnt_q;
        held_d = stall && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end

    assign retire_cnt = cnt_q;
`endif

    assign valid_W    = valid_q;
    assign pcW        = pc_q;
    assign rd_W       = rd_q;
    assign RegWrite_W = we_q;
    assign wd_W       = wd_q;
    assign misalign_W = mis_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_M, RegWrite_M, MemRead_M;
    logic [31:0] pc_M, alu_M, dm_dout_M;
    logic [4:0]  rd_M;
    logic [2:0]  DMType_M;
    logic [1:0]  WDSel_M;
    logic        valid_W, RegWrite_W, misalign_W;
    logic [31:0] pcW, wd_W;
    logic [4:0]  rd_W;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    logic        e_valid, e_we, e_mis;
    logic [31:0] e_pc, e_wd;
    logic [4:0]  e_rd;

    mem_wb_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_M(valid_M), .pc_M(pc_M), .alu_M(alu_M), .dm_dout_M(dm_dout_M),
        .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M),
        .DMType_M(DMType_M), .WDSel_M(WDSel_M),
        .valid_W(valid_W), .pcW(pcW), .rd_W(rd_W), .RegWrite_W(RegWrite_W),
        .wd_W(wd_W),
`ifdef MEM_WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .misalign_W(misalign_W)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] act();
        return {valid_W, pcW, rd_W, RegWrite_W, wd_W, misalign_W};
    endfunction

    function automatic logic [71:0] exp_v();
        return {e_valid, e_pc, e_rd, e_we, e_wd, e_mis};
    endfunction

    // Reference behaviour from the architectural rules, applied at the next edge
    task automatic model_edge();
        int unsigned off, b, h, ld;
        bit half, bytet, word, m;
        if (reset || flush) begin
            e_valid = 0; e_pc = RST_PC; e_rd = 0; e_we = 0; e_wd = 0; e_mis = 0;
        end else if (!stall) begin
            off   = alu_M % 4;
            half  = (DMType_M == 1) || (DMType_M == 2);
            bytet = (DMType_M == 3) || (DMType_M == 4);
            word  = !half && !bytet;
            b     = (dm_dout_M / (1 << (8 * off))) % 256;
            h     = (off >= 2) ? dm_dout_M / 65536 : dm_dout_M % 65536;
            if (bytet)     ld = (DMType_M == 3 && b >= 128) ? b + 32'hFFFF_FF00 : b;
            else if (half) ld = (DMType_M == 1 && h >= 32768) ? h + 32'hFFFF_0000 : h;
            else           ld = dm_dout_M;
            m = MemRead_M && valid_M && ((half && off % 2 == 1) || (word && off != 0));
            e_valid = valid_M;
            e_pc    = pc_M;
            e_rd    = rd_M;
            e_mis   = m;
            e_we    = RegWrite_M && valid_M && rd_M != 0 && !m;
            e_wd    = m ? 0 : WDSel_M == 1 ? ld : WDSel_M == 2 ? pc_M + 4 : alu_M;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] dm, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic [2:0] dmt, input logic [1:0] wds);
        valid_M = v; pc_M = pc; alu_M = alu; dm_dout_M = dm; rd_M = rd;
        RegWrite_M = rw; MemRead_M = mr; DMType_M = dmt; WDSel_M = wds;
    endtask

    task automatic rand_op();
        set_op($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, 5'($urandom),
               1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        set_op(1, 32'h1234_5678, 32'h55, 32'hFFFF_FFFF, 5'd7, 1, 0, 3'd0, 2'd0);
        tick(); tick();
        reset = 0;
        set_op(0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 3'd0, 2'd0);
        vectors++;
        if (act() !== {1'b0, RST_PC, 5'd0, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %h want %h", act(), {1'b0, RST_PC, 5'd0, 1'b0, 32'd0, 1'b0});
        end
        tick();
        vectors++;
        if (act() !== exp_v() || valid_W !== 1'b0 || RegWrite_W !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_bubble: got %h want %h", act(), exp_v());
        end
    endtask

    task automatic test_loads();
        logic [2:0]  dmt [4] = '{3'b011, 3'b100, 3'b010, 3'b001};
        logic [31:0] alu [4] = '{32'h1003, 32'h1003, 32'h2002, 32'h2001};
        logic [31:0] dm  [4] = '{32'h80FF_0011, 32'h80FF_0011, 32'hBEEF_1234, 32'hBEEF_1234};
        logic [31:0] wd  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'h0};
        logic        we  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        mi  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            set_op(1, 32'h400 + 32'(i * 4), alu[i], dm[i], 5'd5, 1, 1, dmt[i], 2'b01);
            tick();
            vectors++;
            if (wd_W !== wd[i] || RegWrite_W !== we[i] || misalign_W !== mi[i] ||
                rd_W !== 5'd5 || valid_W !== 1'b1 || act() !== exp_v()) begin
                errors++;
                $display("FAIL load%0d: wd=%h we=%b mis=%b rd=%0d want wd=%h we=%b mis=%b rd=5",
                         i, wd_W, RegWrite_W, misalign_W, rd_W, wd[i], we[i], mi[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            set_op(1, $urandom, $urandom, $urandom, 5'($urandom), 1, 1,
                   3'($urandom), 2'b01);
            tick();
            vectors++;
            if (act() !== exp_v()) begin
                errors++;
                $display("FAIL rand_load%0d: got %h want %h", i, act(), exp_v());
            end
        end
    endtask

    task automatic test_jal();
        set_op(1, 32'hFFFF_FFFC, 32'h9999, 32'h0, 5'd1, 1, 0, 3'd0, 2'b10);
        tick();
        vectors++;
        if (wd_W !== 32'h0 || RegWrite_W !== 1'b1 || rd_W !== 5'd1 || pcW !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL jal_wrap: wd=%h we=%b rd=%0d pc=%h want 0 1 1 fffffffc",
                     wd_W, RegWrite_W, rd_W, pcW);
        end
        rd_M = 5'd0;
        tick();
        vectors++;
        if (RegWrite_W !== 1'b0 || valid_W !== 1'b1) begin
            errors++;
            $display("FAIL jal_x0: we=%b valid=%b want 0 1", RegWrite_W, valid_W);
        end
    endtask

    task automatic test_stall();
        logic [71:0] snap;
`ifdef MEM_WB_RETIRE_CNT_EN
        logic [63:0] c0;
`endif
        set_op(1, 32'h500, 32'h1234, 32'h0, 5'd3, 1, 0, 3'd0, 2'b00);
        tick();
`ifdef MEM_WB_RETIRE_CNT_EN
        c0 = retire_cnt;
`endif
        snap = {1'b1, 32'h500, 5'd3, 1'b1, 32'h1234, 1'b0};
        vectors++;
        if (act() !== snap) begin
            errors++;
            $display("FAIL alu_load: got %h want %h", act(), snap);
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            tick();
            vectors++;
            if (act() !== snap) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h want %h", i, act(), snap);
            end
        end
        stall = 0;
        set_op(1, 32'h504, 32'hCAFE, 32'h0, 5'd9, 1, 0, 3'd0, 2'b11);
        tick();
        vectors++;
        if (wd_W !== 32'hCAFE || rd_W !== 5'd9 || pcW !== 32'h504 || act() !== exp_v()) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", act(), exp_v());
        end
        set_op(0, 32'h508, 32'h0, 32'h0, 5'd0, 0, 0, 3'd0, 2'b00);
        tick();
`ifdef MEM_WB_RETIRE_CNT_EN
        vectors++;
        if (retire_cnt - c0 !== 64'd2) begin
            errors++;
            $display("FAIL retire_cnt: delta=%0d want 2", retire_cnt - c0);
        end
`endif
    endtask

    task automatic test_flush();
        set_op(1, 32'h600, 32'h77, 32'h0, 5'd4, 1, 0, 3'd0, 2'b00);
        tick();
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0;
        vectors++;
        if (valid_W !== 1'b0 || RegWrite_W !== 1'b0 || pcW !== RST_PC || wd_W !== 32'h0) begin
            errors++;
            $display("FAIL flush_stall: valid=%b we=%b pc=%h wd=%h want 0 0 %h 0",
                     valid_W, RegWrite_W, pcW, wd_W, RST_PC);
        end
        tick();
        stall = 1; reset = 1;
        tick();
        stall = 0; reset = 0;
        vectors++;
        if (act() !== {1'b0, RST_PC, 5'd0, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_stall: got %h want %h", act(), {1'b0, RST_PC, 5'd0, 1'b0, 32'd0, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_op();
            stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 9) == 0;
            reset = $urandom_range(0, 29) == 0;
            tick();
            vectors++;
            if (act() !== exp_v()) begin
                errors++;
                $display("FAIL random%0d: got %h want %h", i, act(), exp_v());
            end
        end
        stall = 0; flush = 0; reset = 0;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_jal();
        test_stall();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the pipelined RISC-V core; sits directly downstream of the data memory and consumes its raw word read data.
- Extracts and extends the addressed byte, halfword or word, and flags misaligned loads.
- Selects the writeback value and registers everything into the WB stage.
- Drives the register-file write port, the WB-to-EX forwarding source and the pcW trace output.

Parameters:
- XLEN, 32, data and address width
- RESET_PC, 32'h0000_0000, value of pcW while reset is asserted or after a flush

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all WB registers unchanged
- flush  in  1  load a bubble into WB
- valid_M  in  1  MEM-stage instruction is real
- pc_M  in  XLEN  PC of MEM-stage instruction
- alu_M  in  XLEN  ALU result; also the data memory byte address
- dm_dout_M  in  XLEN  raw aligned word from data memory
- rd_M  in  5  destination register
- RegWrite_M  in  1  instruction writes rd
- MemRead_M  in  1  instruction is a load
- DMType_M  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 treated as lw
- WDSel_M  in  2  writeback source: 00 ALU, 01 memory, 10 pc_M+4, 11 ALU
- valid_W  out  1  WB instruction is real
- pcW  out  XLEN  PC of WB instruction
- rd_W  out  5  register-file write address
- RegWrite_W  out  1  register-file write enable
- wd_W  out  XLEN  register-file write data; also the forwarding data
- misalign_W  out  1  WB instruction was a misaligned load

Behaviour:
- Register priority each rising edge: reset > flush > stall > normal load.
- Reset outputs: valid_W=0, pcW=RESET_PC, rd_W=0, RegWrite_W=0, wd_W=0, misalign_W=0.
- Flush: same values as reset; the flushed instruction never retires.
- Stall without flush: every WB register holds its value, including RegWrite_W. The register-file write repeats, which is harmless.
- Normal: WB registers take the MEM-stage values computed below. Latency 1 cycle MEM to WB. There is no combinational path from inputs to outputs.
- Load extraction (combinational, uses off = alu_M[1:0]):
  - lb/lbu: byte dm_dout_M[8*off+7 : 8*off], sign- or zero-extended.
  - lh/lhu: half at dm_dout_M[15:0] if off[1]=0, else [31:16], sign- or zero-extended.
  - lw: full dm_dout_M.
- Misalignment:
  - Conditions: MemRead_M=1 and valid_M=1 and either (word type with off!=0) or (lh/lhu with off[0]=1).
  - Result: misalign_W=1, RegWrite_W=0, wd_W=0; valid_W and pcW still update.
- Writeback mux: WDSel 01 selects the loaded value, 10 selects pc_M+4 (wraps mod 2^32), 00 and 11 select alu_M.
- RegWrite_W = RegWrite_M & valid_M & (rd_M!=0) & !misalign. An rd of x0 never produces a write or a forwarding hit.
- If valid_M=0 in a normal cycle, the stage loads a bubble: valid_W=0, RegWrite_W=0, pcW=pc_M.
- Reset asserted mid-stall is still reset: it clears everything.
- flush and stall both high: flush wins.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- When defined, the block adds an output retire_cnt (64 bits).
- retire_cnt is cleared by reset.
- It increments by 1 on each rising edge where valid_W=1 and the previous cycle was not a stall hold. Each instruction is counted once even if it is held.
- It wraps at 2^64-1 to 0.
- Without the macro there is no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with valid_M=0 -> all outputs equal reset values; pcW=RESET_PC.
- lb: alu_M=0x1003, dm_dout_M=0x80FF_0011, DMType=011, WDSel=01, rd=5 -> one cycle later wd_W=0xFFFF_FF80, rd_W=5, RegWrite_W=1. Same stimulus as lbu -> wd_W=0x0000_0080.
- lhu: alu_M=0x2002, dm_dout_M=0xBEEF_1234, DMType=010 -> wd_W=0x0000_BEEF. lh with alu_M=0x2001 -> misalign_W=1, RegWrite_W=0, wd_W=0.
- jal writeback: pc_M=0xFFFF_FFFC, WDSel=10, rd=1 -> wd_W=0x0000_0000 (wrap). Same instruction with rd=0 -> RegWrite_W=0.
- ALU op: alu_M=0x1234 loaded, then stall held 3 cycles while inputs change -> outputs frozen. On release, the new inputs appear after 1 cycle. With the macro defined, retire_cnt has increased by exactly 2.
- flush and stall asserted together with a valid ALU op -> next cycle valid_W=0, RegWrite_W=0, pcW=RESET_PC.
